// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: producer write port plus the tx_en/tx_data/uart_tx_busy uart handshake.
interface uart_tx_feeder_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       uart_tx_busy;
  modport master (output wr_en, wr_data, uart_tx_busy, input tx_en, tx_data);
  modport slave (input wr_en, wr_data, uart_tx_busy, output tx_en, tx_data);
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that drains into the uart one request at a time,
// aborting a request (and discarding its byte) if the uart never acknowledges it.
module uart_tx_feeder #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  uart_tx_feeder_if.slave   bus,
  input  logic              i_clr_overflow,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_level,
  output logic              o_overflow,
  output logic              o_ack_timeout
);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;
  state_t            r_state, w_next;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_tx_data;
  logic              r_overflow, r_ack_timeout;
  logic              w_push, w_pop, w_load, w_expire;
  assign o_level       = r_level;
  assign o_full        = r_level == (ADDR_W+1)'(DEPTH);
  assign o_empty       = r_level == '0;
  assign o_overflow    = r_overflow;
  assign o_ack_timeout = r_ack_timeout;
  assign bus.tx_en     = r_state == REQ;
  assign bus.tx_data   = r_tx_data;
  assign w_push   = bus.wr_en && !o_full;
  assign w_load   = r_state == IDLE && !o_empty && !bus.uart_tx_busy;
  // An acknowledge in the last timeout cycle still counts as a normal send
  assign w_expire = r_state == REQ && !bus.uart_tx_busy && r_cnt == CNT_W'(ACK_TIMEOUT - 1);
  assign w_pop    = (r_state == REQ && bus.uart_tx_busy) || w_expire;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      w_next = w_load ? REQ : IDLE;
      REQ:       w_next = bus.uart_tx_busy ? WAIT_DONE : (w_expire ? IDLE : REQ);
      WAIT_DONE: w_next = bus.uart_tx_busy ? WAIT_DONE : IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_cnt         <= '0;
      r_tx_data     <= '0;
      r_overflow    <= 1'b0;
      r_ack_timeout <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level       <= r_level + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
      r_cnt         <= r_state == REQ ? r_cnt + 1'b1 : '0;
      if (w_load) r_tx_data <= r_mem[r_rd_ptr];
      r_overflow    <= (bus.wr_en && o_full) || (r_overflow && !i_clr_overflow);
      r_ack_timeout <= r_ack_timeout || w_expire;
    end
  end
  always_ff @(posedge i_sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed and randomized checks of the feeder against a
// queue-based uart model that records every byte it acknowledges.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16, ADDR_W = 4, ACK_TIMEOUT = 1024;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic full, empty, overflow, ack_to;
  logic [ADDR_W:0] level;
  uart_tx_feeder_if bus ();
  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .i_sys_clk(clk), .i_rst_n(rst_n), .bus(bus), .i_clr_overflow(clr),
    .o_full(full), .o_empty(empty), .o_level(level), .o_overflow(overflow), .o_ack_timeout(ack_to)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int frame_len = 5;
  bit uart_on = 1'b0, hold = 1'b0;
  logic busy_auto = 1'b0;
  logic [7:0] rx_q [$];
  int eps = 0;
  logic en_q = 1'b0;
  assign bus.uart_tx_busy = hold | busy_auto;
  // Uart model: acknowledges a request one cycle after seeing it, stays busy frame_len cycles
  always begin
    @(posedge clk);
    #1;
    if (uart_on && bus.tx_en && !bus.uart_tx_busy) begin
      rx_q.push_back(bus.tx_data);
      busy_auto = 1'b1;
      repeat (frame_len) @(posedge clk);
      #1 busy_auto = 1'b0;
    end
  end
  always @(negedge clk) begin
    if (bus.tx_en && !en_q) eps++;
    en_q = bus.tx_en;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (!(empty && !bus.tx_en && !bus.uart_tx_busy) && n < 5000) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(n < 5000), 1);
    repeat (3) tick();
  endtask
  initial begin
    logic [7:0] b [17];
    logic [7:0] exp_q [$];
    int base, e0, cnt, n;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ackto", ack_to, 0);
    chk("rst_txen", bus.tx_en, 0);
    chk("rst_txdata", bus.tx_data, 8'h00);
    rst_n = 1'b1;
    uart_on = 1'b1;
    tick();
    // Single byte latency
    wr(8'h41);
    chk("lat_level", level, 1);
    chk("lat_empty", empty, 0);
    chk("lat_txen_early", bus.tx_en, 0);
    tick();
    chk("lat_txen", bus.tx_en, 1);
    chk("lat_txdata", bus.tx_data, 8'h41);
    tick();
    chk("lat_txen_drop", bus.tx_en, 0);
    chk("lat_popped", level, 0);
    drain();
    // Four bytes, 100-cycle frames
    frame_len = 100;
    base = rx_q.size();
    e0 = eps;
    for (int i = 0; i < 4; i++) wr(8'h41 + 8'(i));
    drain();
    chk("seq_count", rx_q.size() - base, 4);
    for (int i = 0; i < 4; i++) chk("seq_byte", rx_q[base + i], 8'h41 + 8'(i));
    chk("seq_episodes", eps - e0, 4);
    chk("seq_empty", empty, 1);
    // Overflow with uart held busy
    frame_len = 3;
    hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      b[i] = 8'($urandom);
      wr(b[i]);
      if (i == 14) chk("ovf_notfull15", full, 0);
      if (i == 15) begin
        chk("ovf_full16", full, 1);
        chk("ovf_clear16", overflow, 0);
        chk("ovf_level16", level, 16);
      end
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 16);
    bus.wr_en = 1'b1;
    clr = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    chk("ovf_set_priority", overflow, 1);
    tick();
    clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    base = rx_q.size();
    e0 = eps;
    hold = 1'b0;
    drain();
    chk("ovf_sent", rx_q.size() - base, 16);
    for (int i = 0; i < 16; i++) chk("ovf_byte", rx_q[base + i], b[i]);
    chk("ovf_episodes", eps - e0, 16);
    // Write coinciding with acknowledge while at level 3
    uart_on = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) wr(b[i]);
    chk("coin_level3", level, 3);
    hold = 1'b0;
    tick();
    chk("coin_req", bus.tx_en, 1);
    chk("coin_head", bus.tx_data, b[0]);
    hold = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = b[3];
    tick();
    bus.wr_en = 1'b0;
    chk("coin_level", level, 3);
    chk("coin_txen", bus.tx_en, 0);
    base = rx_q.size();
    hold = 1'b0;
    uart_on = 1'b1;
    drain();
    chk("coin_count", rx_q.size() - base, 3);
    for (int i = 0; i < 3; i++) chk("coin_byte", rx_q[base + i], b[i + 1]);
    // Acknowledge timeout
    uart_on = 1'b0;
    wr(8'h55);
    tick();
    cnt = 0;
    while (bus.tx_en && cnt < 2000) begin
      cnt++;
      tick();
    end
    chk("to_cycles", cnt, ACK_TIMEOUT);
    chk("to_flag", ack_to, 1);
    chk("to_level", level, 0);
    chk("to_txen", bus.tx_en, 0);
    repeat (5) tick();
    chk("to_idle", bus.tx_en, 0);
    // Reset during WAIT_DONE with five bytes queued
    uart_on = 1'b1;
    frame_len = 50;
    for (int i = 0; i < 6; i++) wr(8'(8'h60 + i));
    repeat (4) tick();
    chk("rw_level5", level, 5);
    chk("rw_busy", bus.uart_tx_busy, 1);
    base = rx_q.size();
    e0 = eps;
    #2 rst_n = 1'b0;
    #1;
    chk("rw_txen", bus.tx_en, 0);
    chk("rw_level", level, 0);
    chk("rw_empty", empty, 1);
    chk("rw_ackto", ack_to, 0);
    tick();
    rst_n = 1'b1;
    repeat (200) tick();
    chk("rw_no_req", eps - e0, 0);
    chk("rw_no_rx", rx_q.size() - base, 0);
    // Randomized bursts, expected output is the written sequence in order
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, DEPTH);
      frame_len = $urandom_range(1, 20);
      base = rx_q.size();
      e0 = eps;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(8'($urandom));
        wr(exp_q[i]);
        repeat ($urandom_range(0, 2)) tick();
      end
      drain();
      chk("rnd_count", rx_q.size() - base, n);
      chk("rnd_episodes", eps - e0, n);
      for (int i = 0; i < n && base + i < rx_q.size(); i++) chk("rnd_byte", rx_q[base + i], exp_q[i]);
    end
    chk("rnd_ovf", overflow, 0);
    chk("rnd_ackto", ack_to, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
